// File: rtl/counter_arbiter_pkg.sv
// Shared encodings for the counter arbiter: requester operations and FSM states.
package counter_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_INC = 2'b01,
    OP_DEC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_GRANT   = 2'b01,
    S_RELEASE = 2'b10
  } state_t;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/counter_core.sv
// WIDTH-bit up/down counter with wrap flags; updates only when en is high.
module counter_core
  import counter_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             en,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = '1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      udf <= 1'b0;
      if (en) begin
        case (op)
          OP_INC: begin
            count <= count + ONE;
            ovf   <= (count == MAX);
          end
          OP_DEC: begin
            count <= count - ONE;
            udf   <= (count == '0);
          end
          OP_CLR:  count <= '0;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin req/gnt/done arbiter giving two requesters exclusive use of one counter.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  output logic [1:0]       gnt,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             udf
);

  state_t state, state_nxt;
  logic   owner;
  logic   rr;
  logic   win;
  logic   en;
  op_t    op_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win = rr;
    if (req == 2'b01)      win = 1'b0;
    else if (req == 2'b10) win = 1'b1;
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (|req) state_nxt = S_GRANT;
      S_GRANT:   state_nxt = S_RELEASE;
      S_RELEASE: if (!req[owner]) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Owner and op are captured only on the grant edge, so later op/req changes are ignored.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      owner <= 1'b0;
      op_q  <= OP_NOP;
      rr    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (state == S_GRANT);
      if (state == S_IDLE && |req) begin
        owner <= win;
        op_q  <= win ? op_t'(op1) : op_t'(op0);
      end
      if (state == S_RELEASE && !req[owner]) rr <= ~owner;
    end
  end

  always_comb begin
    gnt  = 2'b00;
    busy = 1'b0;
    en   = 1'b0;
    case (state)
      S_GRANT: begin
        gnt  = onehot(owner);
        busy = 1'b1;
        en   = 1'b1;
      end
      S_RELEASE: begin
        gnt  = onehot(owner);
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .CLR   (CLR),
    .en    (en),
    .op    (op_q),
    .count (count),
    .ovf   (ovf),
    .udf   (udf)
  );

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: expected results queued at issue, checked on done.
module tb_counter_arbiter;
  import counter_arbiter_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             CLR;
  logic [1:0]       req, op0, op1;
  logic [1:0]       gnt;
  logic             done, busy, ovf, udf;
  logic [WIDTH-1:0] count;

  typedef struct packed {
    logic [1:0]       gnt;
    logic [WIDTH-1:0] count;
    logic             ovf;
    logic             udf;
  } exp_t;

  exp_t             sb_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] m_count;
  logic             m_rr;
  logic [1:0]       g_seen;

  counter_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .CLR(CLR), .req(req), .op0(op0), .op1(op1),
    .gnt(gnt), .done(done), .busy(busy), .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Results are compared whenever the DUT reports completion.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_extra_done", done, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_gnt", gnt, e.gnt);
        check("sb_count", count, e.count);
        check("sb_ovf", ovf, e.ovf);
        check("sb_udf", udf, e.udf);
      end
    end
  end

  task automatic txn(input logic [1:0] r, input logic [1:0] a, input logic [1:0] b,
                     output logic [1:0] g);
    logic       w;
    logic [1:0] o;
    int         c;
    exp_t       e;
    w = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : m_rr;
    o = w ? b : a;
    c = int'(m_count);
    e.gnt = w ? 2'b10 : 2'b01;
    e.ovf = 1'b0;
    e.udf = 1'b0;
    case (o)
      2'b01: begin e.ovf = (c == 15); c = (c + 1) % 16; end
      2'b10: begin e.udf = (c == 0);  c = (c + 15) % 16; end
      2'b11: c = 0;
      default: ;
    endcase
    e.count = WIDTH'(c);
    sb_q.push_back(e);
    m_count = e.count;
    m_rr    = ~w;

    req = r; op0 = a; op1 = b;
    @(negedge clk);
    g = gnt;
    check("grant_gnt", gnt, e.gnt);
    check("grant_busy", busy, 1);
    check("grant_done", done, 0);
    op0 = ~a; op1 = ~b;
    @(negedge clk);
    check("done_pulse", done, 1);
    req[w] = 1'b0;
    @(negedge clk);
    check("release_gnt", gnt, 2'b00);
    check("release_busy", busy, 0);
    check("release_pulses", {done, ovf, udf}, 3'b000);
  endtask

  initial begin
    CLR = 1'b1; req = 2'b00; op0 = 2'b00; op1 = 2'b00;
    m_count = '0; m_rr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_flags", {done, ovf, udf}, 3'b000);
    CLR = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      txn(2'b01, OP_INC, OP_NOP, g_seen);
      check("single_count", count, i + 1);
    end

    #2 CLR = 1'b1;
    #1;
    check("async_count", count, 0);
    check("async_gnt", gnt, 2'b00);
    check("async_busy", busy, 0);
    @(negedge clk);
    CLR = 1'b0; m_count = '0; m_rr = 1'b0;
    @(negedge clk);

    repeat (4) txn(2'b01, OP_INC, OP_NOP, g_seen);
    txn(2'b10, OP_NOP, OP_INC, g_seen);
    check("preload_count", count, 5);
    txn(2'b11, OP_INC, OP_DEC, g_seen);
    check("contend_first_gnt", g_seen, 2'b01);
    check("contend_first_count", count, 6);
    txn(2'b11, OP_INC, OP_DEC, g_seen);
    check("contend_second_gnt", g_seen, 2'b10);
    check("contend_second_count", count, 5);

    repeat (10) txn(2'b01, OP_INC, OP_NOP, g_seen);
    txn(2'b01, OP_INC, OP_NOP, g_seen);
    check("wrap_inc_count", count, 0);
    txn(2'b10, OP_NOP, OP_DEC, g_seen);
    check("wrap_dec_count", count, 15);
    repeat (6) txn(2'b01, OP_DEC, OP_NOP, g_seen);
    txn(2'b01, OP_CLR, OP_NOP, g_seen);
    check("clear_count", count, 0);
    txn(2'b01, OP_INC, OP_NOP, g_seen);
    txn(2'b01, OP_NOP, OP_NOP, g_seen);
    check("nop_count", count, 1);

    repeat (6) txn(2'b01, OP_INC, OP_NOP, g_seen);
    check("abort_pre_count", count, 7);
    req = 2'b01; op0 = OP_INC;
    @(negedge clk);
    check("abort_gnt_before", gnt, 2'b01);
    #2 CLR = 1'b1;
    #1;
    check("abort_count", count, 0);
    check("abort_gnt", gnt, 2'b00);
    check("abort_busy", busy, 0);
    req = 2'b00;
    @(negedge clk);
    check("abort_no_done", done, 0);
    check("abort_count_held", count, 0);
    CLR = 1'b0; m_count = '0; m_rr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      txn(2'b11, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), g_seen);
      check("fair_gnt", g_seen, (i % 2 == 1) ? 2'b10 : 2'b01);
    end

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
